// File: rtl/load_store_unit.sv
// Load/store unit: CPU request handshake to a byte-lane data memory with one-cycle registered read.
// Optional LSU_MISALIGN_TRAP_EN faults misaligned half/word requests instead of issuing them.
module load_store_unit #(
    parameter logic [31:0] IDLE_ADDR  = 32'h0000_0000,
    parameter bit          WRITE_RESP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] memory_address,
    output logic [31:0] memory_in,
    output logic [1:0]  memory_size,
    output logic        memory_write_enable,
    input  logic [31:0] memory_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t      state;
    logic        write_q;
    logic        signed_q;
    logic        misaligned;
    logic [31:0] load_ext;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // memory_size is still held during CAPTURE, so it selects the extension width
    always_comb begin
        case (memory_size)
            2'b00:   load_ext = {{24{signed_q & memory_out[7]}}, memory_out[7:0]};
            2'b01:   load_ext = {{16{signed_q & memory_out[15]}}, memory_out[15:0]};
            default: load_ext = memory_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            req_ready           <= 1'b1;
            resp_valid          <= 1'b0;
            resp_error          <= 1'b0;
            resp_rdata          <= 32'h0;
            memory_address      <= IDLE_ADDR;
            memory_in           <= 32'h0;
            memory_size         <= 2'b00;
            memory_write_enable <= 1'b0;
            write_q             <= 1'b0;
            signed_q            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        signed_q  <= req_signed;
                        req_ready <= 1'b0;
                        if (misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state               <= ACCESS;
                            memory_address      <= req_addr;
                            memory_size         <= req_size;
                            memory_in           <= req_wdata;
                            memory_write_enable <= req_write;
                        end
                    end
                end
                ACCESS: begin
                    memory_write_enable <= 1'b0;
                    memory_in           <= 32'h0;
                    if (write_q) begin
                        memory_address <= IDLE_ADDR;
                        memory_size    <= 2'b00;
                        resp_rdata     <= 32'h0;
                        resp_error     <= 1'b0;
                        if (WRITE_RESP) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            req_ready <= 1'b1;
                        end
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    resp_rdata     <= load_ext;
                    resp_error     <= 1'b0;
                    resp_valid     <= 1'b1;
                    memory_address <= IDLE_ADDR;
                    memory_size    <= 2'b00;
                    state          <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
